// File: rtl/icache_refill_arbiter_if.sv
// icache_refill_arbiter_if: line-refill handshake (read/address out of master, readdata/busywait back from slave)
interface icache_refill_arbiter_if #(parameter int ADDR_W = 28, parameter int LINE_W = 128);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] readdata;
  logic              busywait;
  modport master(output read, output address, input readdata, input busywait);
  modport slave(input read, input address, output readdata, output busywait);
endinterface

// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter: round-robin I/D refill arbiter (clock, reset, i_port/d_port slaves, mem_port master to 16-beat block memory)
module icache_refill_arbiter #(parameter int ADDR_W = 28, parameter int LINE_W = 128) (
  input logic clock,
  input logic reset,
  icache_refill_arbiter_if.slave  i_port,
  icache_refill_arbiter_if.slave  d_port,
  icache_refill_arbiter_if.master mem_port
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic       win_d;
  assign win_d = d_port.read & (~i_port.read | ~last_grant);
  assign i_port.busywait = i_port.read & ~(state == RESP & ~owner);
  assign d_port.busywait = d_port.read & ~(state == RESP & owner);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem_port.read    <= 1'b0;
      mem_port.address <= {ADDR_W{1'b0}};
      i_port.readdata  <= {LINE_W{1'b0}};
      d_port.readdata  <= {LINE_W{1'b0}};
      owner            <= 1'b0;
      last_grant       <= 1'b1;
    end else begin
      case (state)
        IDLE: if (i_port.read | d_port.read) begin
          state            <= MEM;
          mem_port.read    <= 1'b1;
          mem_port.address <= win_d ? d_port.address : i_port.address;
          owner            <= win_d;
        end
        MEM: if (!mem_port.busywait) begin
          state         <= RESP;
          mem_port.read <= 1'b0;
          last_grant    <= owner;
          if (owner) d_port.readdata <= mem_port.readdata;
          else i_port.readdata <= mem_port.readdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/icache_refill_arbiter.md
# icache_refill_arbiter

Two-port refill arbiter and sequencer for the shared 128-bit block-read instruction memory. It accepts line-refill requests from the instruction-cache miss path (I port) and a second read-only refill client (D port: the data-cache read-miss or prefetch path). It grants one requester at a time with round-robin priority and drives the memory's `read`/`address` handshake until the 16-beat block is complete. It then returns the line to the granted requester and releases that requester's `busywait`.

## Interface
- `ADDR_W`, 28: line address width (byte address >> 4).
- `LINE_W`, 128: line width in bits.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-port refill request; held until the response cycle.
- `i_address`  in  ADDR_W  I-port line address.
- `i_readdata`  out  LINE_W  I-port returned line.
- `i_busywait`  out  1  I-port stall.
- `d_read`, `d_address`, `d_readdata`, `d_busywait`: D-port ports, identical to the I-port ports.
- `mem_read`  out  1  memory read strobe.
- `mem_address`  out  ADDR_W  memory line address.
- `mem_readdata`  in  LINE_W  memory line data.
- `mem_busywait`  in  1  memory stall.

## Operation
- **State machine:**
  - IDLE: `mem_read` = 0.
    - If any request is pending, latch the winner's address into `mem_address`, record the winner in `owner`, and go to MEM.
  - MEM: `mem_read` = 1, `mem_address` held.
    - When `mem_busywait` is sampled 0 at a rising edge, drop `mem_read` and go to RESP.
  - RESP (one cycle):
    - Register `mem_readdata` into the owner's `*_readdata`.
    - Drive the owner's `*_busywait` low.
    - Update `last_grant` to `owner`.
    - Go to IDLE.
- **Arbitration:**
  - Only one requester active: that requester wins.
  - Both active: the requester that is not `last_grant` wins (round-robin).
- **Busywait:**
  - `x_busywait` = `x_read` AND NOT (state == RESP AND owner == x). This is combinational from `x_read`.
  - A requester with `read` low sees `busywait` = 0.
- **Address capture:** `mem_address` captures the winner's address at grant. Address changes by the requester during MEM are ignored.
- **Output retention:** `*_readdata` is updated only in RESP for the owner and holds its value otherwise. The non-owner's `readdata` is never disturbed.
- **Request deassert mid-transfer:** if the owner drops `read` during MEM, the transfer still completes, the line is still written to its `readdata`, and no busywait is visible. There is no abort: the memory counter must complete its wrap to 0.
- **Back-to-back requests:** a requester still holding `read` after its RESP cycle is treated as a new request in the following IDLE cycle.
- **Reset (any state, including mid-MEM):**
  - State = IDLE, `mem_read` = 0, `mem_address` = 0.
  - `i_readdata` = `d_readdata` = 0.
  - `owner` = I, `last_grant` = D, so I wins the first tie.
  - The memory resets its beat counter on the same reset, so no partial beat state survives.

## Timing
- **Reset values:** `mem_read` 0, `mem_address` 0, `*_readdata` 0. `*_busywait` = `*_read`, as set by the combinational rule.
- **Grant latency:** a request present before rising edge E0 while in IDLE gives `mem_read` = 1 from E0.
- **Memory phase:** the memory takes 16 rising edges with `read` high; `mem_busywait` falls after the 15th edge. The arbiter samples it low at the 16th edge, E16, and enters RESP.
- **Response cycle:** RESP is the cycle after E16.
  - `*_readdata` is valid and `busywait` is 0 for the owner in this cycle.
  - The requester samples the line at E17.
- **Latency:** request-to-data is 17 cycles. The minimum issue spacing for back-to-back grants is 18 cycles, because IDLE lasts one cycle after RESP.
- **Gap guarantee:** `mem_read` is never high in RESP or IDLE. This gives at least 2 low cycles between transfers.
- **Simultaneous events:** a new request arriving in the same cycle the other requester is in RESP is arbitrated in the next IDLE cycle, using the updated `last_grant`.

## Test plan
- **Reset and idle:** assert reset, then release it with no requests -> `mem_read` = 0, `mem_address` = 0, `i_readdata` = `d_readdata` = 0, both busywaits 0.
- **Single I refill:** memory preloaded with bytes 0x00..0x0F at line 0; set `i_read` = 1, `i_address` = 0 ->
  - `mem_read` is high for exactly 16 cycles.
  - `i_busywait` is low only in cycle 17.
  - `i_readdata` = 0x0F0E...0100.
  - `d_busywait` stays 0 throughout.
- **Simultaneous requests after reset:** I at line 1, D at line 2 ->
  - I is served first, then D.
  - `d_busywait` stays high about 35 cycles.
  - `d_readdata` = the contents of line 2.
  - The two `mem_read` bursts are separated by at least 2 low cycles.
- **Round-robin fairness:** I and D both hold `read` continuously for 4 transfers -> grant order I, D, I, D, with no starvation.
- **Reset mid-transfer:** pulse reset at cycle 8 of MEM ->
  - `mem_read` drops immediately and the state returns to IDLE.
  - A re-issued request completes in 17 cycles with correct data.
- **Owner drops `read` mid-MEM:** ->
  - The transfer completes, `i_readdata` is updated, and `i_busywait` is 0 throughout.
  - A pending D request is granted in the following IDLE cycle.
